mem_arbiter: RTL and testbench

//  Shares the single line-wide memory port between the I-cache and D-cache controllers.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between the I-cache and the
// D-cache. Requests are level-held; one owner at a time is forwarded to memory
// and only that owner sees in_mem_ready. Every completed transaction is
// followed by a one-cycle DRAIN so the requester can drop its enable before
// re-arbitration.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break
// (the port that did not complete last wins). Otherwise D has fixed priority.
module mem_arbiter #(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_i_mem_read_en,
  input  logic                       in_i_mem_write_en,
  input  logic [ADDR_WIDTH-1:0]      in_i_mem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_i_mem_write_data,
  output logic                       out_i_mem_ready,
  output logic [CACHE_LINE_SIZE-1:0] out_i_mem_read_data,
  input  logic                       in_d_mem_read_en,
  input  logic                       in_d_mem_write_en,
  input  logic [ADDR_WIDTH-1:0]      in_d_mem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_d_mem_write_data,
  output logic                       out_d_mem_ready,
  output logic [CACHE_LINE_SIZE-1:0] out_d_mem_read_data,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [ADDR_WIDTH-1:0]      out_mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
  input  logic                       in_mem_ready,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
  output logic [1:0]                 out_grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state;
  logic   last_grant_d;  // 1: D completed most recently, 0: I
  logic   req_i;
  logic   req_d;
  logic   win_d;

  assign req_i = in_i_mem_read_en | in_i_mem_write_en;
  assign req_d = in_d_mem_read_en | in_d_mem_write_en;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie the port that did not complete last wins.
  assign win_d = req_d & (~req_i | ~last_grant_d);
`else
  // D-cache has fixed priority over the I-cache.
  assign win_d = req_d;
`endif

  // Read lines are broadcast; only the ready pulse is steered.
  assign out_i_mem_read_data = in_mem_read_data;
  assign out_d_mem_read_data = in_mem_read_data;

  // Arbitration state machine: owner selection, completion, abort and drain.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_i || req_d) state <= win_d ? BUSY_D : BUSY_I;
        end
        BUSY_I: begin
          if (in_mem_ready) begin
            state        <= DRAIN;
            last_grant_d <= 1'b0;
          end else if (!req_i) begin
            state <= IDLE;
          end
        end
        BUSY_D: begin
          if (in_mem_ready) begin
            state        <= DRAIN;
            last_grant_d <= 1'b1;
          end else if (!req_d) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side mux and ready steering, decoded from the current owner.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    out_mem_read_en    = 1'b0;
    out_mem_write_en   = 1'b0;
    out_mem_addr       = '0;
    out_mem_write_data = '0;
    out_grant          = 2'b00;
    out_i_mem_ready    = 1'b0;
    out_d_mem_ready    = 1'b0;
    case (state)
      BUSY_I: begin
        out_mem_read_en    = in_i_mem_read_en;
        out_mem_write_en   = in_i_mem_write_en;
        out_mem_addr       = in_i_mem_addr;
        out_mem_write_data = in_i_mem_write_data;
        out_grant          = 2'b01;
        out_i_mem_ready    = in_mem_ready;
      end
      BUSY_D: begin
        out_mem_read_en    = in_d_mem_read_en;
        out_mem_write_en   = in_d_mem_write_en;
        out_mem_addr       = in_d_mem_addr;
        out_mem_write_data = in_d_mem_write_data;
        out_grant          = 2'b10;
        out_d_mem_ready    = in_mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked cycle by cycle against a transaction-level ownership model.
// Expected arbitration follows MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;
  localparam int W = 128;
  localparam int A = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_rd, i_wr, d_rd, d_wr;
  logic [A-1:0] i_addr, d_addr;
  logic [W-1:0] i_wdata, d_wdata;
  logic         i_ready, d_ready;
  logic [W-1:0] i_rdata, d_rdata;
  logic         m_rd, m_wr;
  logic [A-1:0] m_addr;
  logic [W-1:0] m_wdata;
  logic         m_ready;
  logic [W-1:0] m_rdata;
  logic [1:0]   grant;

  always #5 clk = ~clk;

  mem_arbiter #(.CACHE_LINE_SIZE(W), .ADDR_WIDTH(A)) dut (
    .clk(clk), .reset(reset),
    .in_i_mem_read_en(i_rd), .in_i_mem_write_en(i_wr),
    .in_i_mem_addr(i_addr), .in_i_mem_write_data(i_wdata),
    .out_i_mem_ready(i_ready), .out_i_mem_read_data(i_rdata),
    .in_d_mem_read_en(d_rd), .in_d_mem_write_en(d_wr),
    .in_d_mem_addr(d_addr), .in_d_mem_write_data(d_wdata),
    .out_d_mem_ready(d_ready), .out_d_mem_read_data(d_rdata),
    .out_mem_read_en(m_rd), .out_mem_write_en(m_wr),
    .out_mem_addr(m_addr), .out_mem_write_data(m_wdata),
    .in_mem_ready(m_ready), .in_mem_read_data(m_rdata),
    .out_grant(grant)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ownership model: who owns the memory port (0 none, 1 I, 2 D), whether a
  // post-completion cooldown cycle is pending, and who completed last.
  int owner;
  bit cooldown;
  int last_done;

  // Seen on the DUT this cycle; used only to steer stimulus and for tallies.
  bit got_ir, got_dr;
  int cnt_ir, cnt_dr;
  logic [W-1:0] cap_i_data;
  logic [1:0] prev_grant;
  logic [1:0] grant_q[$];

  function automatic int pick(input bit ri, input bit rd, input int last);
    if (!ri && !rd) return 0;
    if (ri && !rd) return 1;
    if (rd && !ri) return 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return (last == 1) ? 2 : 1;
`else
    return 2;
`endif
  endfunction

  task automatic model_reset();
    owner = 0; cooldown = 0; last_done = 2; prev_grant = 2'b00;
  endtask

  // Called just after a falling edge with inputs settled: compare, advance.
  task automatic step();
    logic         e_rd, e_wr, e_ir, e_dr;
    logic [A-1:0] e_addr;
    logic [W-1:0] e_wd;
    logic [1:0]   e_g;
    int n_owner, n_last;
    bit n_cool, req_own;
    #1;
    e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0; e_g = 2'b00; e_ir = 0; e_dr = 0;
    if (owner == 1) begin
      e_rd = i_rd; e_wr = i_wr; e_addr = i_addr; e_wd = i_wdata; e_g = 2'b01; e_ir = m_ready;
    end else if (owner == 2) begin
      e_rd = d_rd; e_wr = d_wr; e_addr = d_addr; e_wd = d_wdata; e_g = 2'b10; e_dr = m_ready;
    end
    check("mem_read_en", W'(m_rd), W'(e_rd));
    check("mem_write_en", W'(m_wr), W'(e_wr));
    check("mem_addr", W'(m_addr), W'(e_addr));
    check("mem_write_data", m_wdata, e_wd);
    check("grant", W'(grant), W'(e_g));
    check("i_ready", W'(i_ready), W'(e_ir));
    check("d_ready", W'(d_ready), W'(e_dr));
    check("i_read_data", i_rdata, m_rdata);
    check("d_read_data", d_rdata, m_rdata);
    got_ir = i_ready; got_dr = d_ready;
    if (i_ready) begin cnt_ir++; cap_i_data = i_rdata; end
    if (d_ready) cnt_dr++;
    if (grant != 2'b00 && prev_grant == 2'b00) grant_q.push_back(grant);
    prev_grant = grant;
    n_owner = owner; n_cool = 0; n_last = last_done;
    if (cooldown) n_owner = 0;
    else if (owner == 0) n_owner = pick(i_rd | i_wr, d_rd | d_wr, last_done);
    else begin
      req_own = (owner == 1) ? (i_rd | i_wr) : (d_rd | d_wr);
      if (m_ready) begin n_cool = 1; n_owner = 0; n_last = owner; end
      else if (!req_own) n_owner = 0;
    end
    @(posedge clk);
    owner = n_owner; cooldown = n_cool; last_done = n_last;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_rd = 0; i_wr = 0; i_addr = '0; i_wdata = '0;
    d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    m_ready = 0; m_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    grant_q.delete();
    cnt_ir = 0; cnt_dr = 0;
  endtask

  typedef struct { bit wr; logic [A-1:0] addr; logic [W-1:0] data; } op_t;
  op_t i_ops[$];
  op_t d_ops[$];

  // Level-held requesters consume their op queues; memory answers on the
  // fourth cycle of each ownership.
  task automatic run_ops(input int i_start, input int max_cycles, input logic [W-1:0] line);
    bit i_act, d_act;
    int busy, c;
    op_t o;
    i_act = 0; d_act = 0; busy = 0;
    for (c = 0; c < max_cycles; c++) begin
      if (!i_act && i_ops.size() > 0 && c >= i_start) begin
        o = i_ops.pop_front();
        i_rd = !o.wr; i_wr = o.wr; i_addr = o.addr; i_wdata = o.data; i_act = 1;
      end
      if (!d_act && d_ops.size() > 0) begin
        o = d_ops.pop_front();
        d_rd = !o.wr; d_wr = o.wr; d_addr = o.addr; d_wdata = o.data; d_act = 1;
      end
      m_ready = (busy == 3);
      m_rdata = line;
      step();
      busy = (prev_grant != 2'b00 && !(got_ir || got_dr)) ? busy + 1 : 0;
      if (got_ir) begin i_rd = 0; i_wr = 0; i_act = 0; end
      if (got_dr) begin d_rd = 0; d_wr = 0; d_act = 0; end
      if (!i_act && !d_act && i_ops.size() == 0 && d_ops.size() == 0) break;
    end
    check("run_completed", W'(c < max_cycles), W'(1));
    m_ready = 0;
    step(); step();
  endtask

  task automatic check_order(input string tag, input logic [1:0] exp[$]);
    check({tag, "_len"}, W'(grant_q.size()), W'(exp.size()));
    for (int k = 0; k < exp.size() && k < grant_q.size(); k++)
      check(tag, W'(grant_q[k]), W'(exp[k]));
  endtask

  task automatic rand_port(inout logic rd, inout logic wr, inout logic [A-1:0] addr,
                           inout logic [W-1:0] wd, input bit done);
    if ((rd || wr) && (done || $urandom_range(31) == 0)) begin
      rd = 0; wr = 0;
    end
    if (!(rd || wr) && $urandom_range(2) == 0) begin
      wr = ($urandom_range(3) == 0);
      rd = !wr;
      addr = $urandom;
      wd = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    logic [1:0] exp_q[$];
    logic [W-1:0] a5_line, dead_line;
    clear_inputs();
    model_reset();
    reset = 1'b1;
    #1;
    check("reset_grant", W'(grant), W'(0));
    check("reset_mem_read_en", W'(m_rd), W'(0));
    a5_line = {16{8'hA5}};
    dead_line = {4{32'hDEADBEEF}};

    // 1: single I read
    do_reset();
    i_ops.push_back('{0, 32'h100, '0});
    run_ops(0, 50, a5_line);
    check("t1_i_ready_count", W'(cnt_ir), W'(1));
    check("t1_d_ready_count", W'(cnt_dr), W'(0));
    check("t1_i_data", cap_i_data, a5_line);
    exp_q = '{2'b01};
    check_order("t1_order", exp_q);

    // 2: simultaneous I and D reads
    do_reset();
    i_ops.push_back('{0, 32'h100, '0});
    d_ops.push_back('{0, 32'h200, '0});
    run_ops(0, 80, a5_line);
    check("t2_i_ready_count", W'(cnt_ir), W'(1));
    check("t2_d_ready_count", W'(cnt_dr), W'(1));
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_q = '{2'b01, 2'b10};
`else
    exp_q = '{2'b10, 2'b01};
`endif
    check_order("t2_order", exp_q);

    // 3: both ports re-request immediately, two lines each
    do_reset();
    i_ops.push_back('{0, 32'h10, '0}); i_ops.push_back('{0, 32'h20, '0});
    d_ops.push_back('{0, 32'h30, '0}); d_ops.push_back('{0, 32'h40, '0});
    run_ops(0, 150, a5_line);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_q = '{2'b10, 2'b10, 2'b01, 2'b01};
`endif
    check_order("t3_order", exp_q);

    // 4: D writeback then refill while I holds a read
    do_reset();
    d_ops.push_back('{1, 32'h2000, dead_line});
    d_ops.push_back('{0, 32'h3000, '0});
    i_ops.push_back('{0, 32'h100, '0});
    run_ops(2, 120, a5_line);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_q = '{2'b10, 2'b01, 2'b10};
`else
    exp_q = '{2'b10, 2'b10, 2'b01};
`endif
    check_order("t4_order", exp_q);

    // 5: asynchronous reset while D owns the port
    do_reset();
    d_rd = 1; d_addr = 32'h200;
    step(); step();
    check("t5_busy_d", W'(grant), W'(2'b10));
    m_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("t5_rst_grant", W'(grant), W'(0));
    check("t5_rst_read_en", W'(m_rd), W'(0));
    check("t5_rst_addr", W'(m_addr), W'(0));
    check("t5_rst_d_ready", W'(d_ready), W'(0));
    model_reset();
    @(negedge clk);
    m_ready = 1'b0;
    reset = 1'b0;
    step(); step();
    check("t5_regrant_d", W'(grant), W'(2'b10));
    d_rd = 0;
    step(); step();

    // 6: I aborts, then a stray memory ready
    do_reset();
    i_rd = 1; i_addr = 32'h100;
    step(); step();
    check("t6_busy_i", W'(grant), W'(2'b01));
    i_rd = 0;
    step();
    check("t6_aborted", W'(grant), W'(0));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    step();
    check("t6_no_i_ready", W'(cnt_ir), W'(0));
    check("t6_no_d_ready", W'(cnt_dr), W'(0));

    // Randomized traffic, including stray readies and aborts
    do_reset();
    got_ir = 0; got_dr = 0;
    for (int n = 0; n < 2000; n++) begin
      rand_port(i_rd, i_wr, i_addr, i_wdata, got_ir);
      rand_port(d_rd, d_wr, d_addr, d_wdata, got_dr);
      m_ready = ($urandom_range(3) == 0);
      m_rdata = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
